// File: rtl/alarm_ctrl_if.sv
// rtl/alarm_ctrl_if.sv - alarm unit control/status bundle
interface alarm_ctrl_if;
  logic        Tick;
  logic [23:0] TimeIn;
  logic [15:0] AlarmIn;
  logic        SetAlarm;
  logic        Arm;
  logic        Snooze;
  logic        Stop;
  logic [15:0] AlarmQ;
  logic        Ring;
  logic        Blink;
  logic        Snoozing;
  logic        BadSet;

  modport master (
    output Tick, TimeIn, AlarmIn, SetAlarm, Arm, Snooze, Stop,
    input  AlarmQ, Ring, Blink, Snoozing, BadSet
  );

  modport slave (
    input  Tick, TimeIn, AlarmIn, SetAlarm, Arm, Snooze, Stop,
    output AlarmQ, Ring, Blink, Snoozing, BadSet
  );
endinterface

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - BCD alarm time store, minute match and ring/snooze FSM
module alarm_ctrl #(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_MAX   = 60,
  parameter int CW         = 9
) (
  input  logic       Clock,
  input  logic       Resetn,
  alarm_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  localparam logic [CW-1:0] RING_LAST = CW'(RING_MAX - 1);
  localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_SEC - 1);

  state_t        state;
  logic [15:0]   alarm_q;
  logic          bad_set_q;
  logic          blink_q;
  logic          match;
  logic          match_q;
  logic          rise;
  logic          set_valid;
  logic [CW-1:0] ring_cnt;
  logic [CW-1:0] snz_cnt;
  logic [3:0]    a_h1, a_h0, a_m1, a_m0;

  assign {a_h1, a_h0, a_m1, a_m0} = bus.AlarmIn;

  // A new alarm time is accepted only as a legal 00:00..23:59 BCD value
  always_comb begin
    set_valid = (a_h0 <= 4'd9) && (a_m0 <= 4'd9) && (a_m1 <= 4'd5) &&
                ((a_h1 <= 4'd1) || ((a_h1 == 4'd2) && (a_h0 <= 4'd3)));
  end

  // Minute-entry detect: only the first cycle of HH:MM:00 counts as a rise
  always_comb begin
    match = (bus.TimeIn[23:8] == alarm_q) && (bus.TimeIn[7:0] == 8'h00);
    rise  = match && !match_q;
  end

  // Alarm register load and invalid-set flag, independent of the FSM
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      alarm_q   <= 16'h0000;
      bad_set_q <= 1'b0;
    end else begin
      bad_set_q <= bus.SetAlarm && !set_valid;
      if (bus.SetAlarm && set_valid)
        alarm_q <= bus.AlarmIn;
    end
  end

  // Previous-cycle match for edge detection
  always_ff @(posedge Clock) begin
    if (!Resetn) match_q <= 1'b0;
    else         match_q <= match;
  end

  // Ring/snooze state machine with Tick-driven counters and blink toggle
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      blink_q  <= 1'b0;
    end else if (!bus.Arm) begin
      state   <= IDLE;
      blink_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= ARMED;
          blink_q <= 1'b0;
        end
        ARMED: begin
          blink_q <= 1'b0;
          if (rise) begin
            state    <= RINGING;
            ring_cnt <= '0;
          end
        end
        RINGING: begin
          if (bus.Stop) begin
            state   <= ARMED;
            blink_q <= 1'b0;
          end else if (bus.Snooze) begin
            state   <= SNOOZE;
            snz_cnt <= '0;
            blink_q <= 1'b0;
          end else if (bus.Tick) begin
            if (ring_cnt == RING_LAST) begin
              state   <= ARMED;
              blink_q <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
              blink_q  <= !blink_q;
            end
          end
        end
        SNOOZE: begin
          blink_q <= 1'b0;
          if (bus.Stop) begin
            state <= ARMED;
          end else if (bus.Tick) begin
            if (snz_cnt == SNZ_LAST) begin
              state    <= RINGING;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.AlarmQ   = alarm_q;
  assign bus.BadSet   = bad_set_q;
  assign bus.Blink    = blink_q;
  assign bus.Ring     = (state == RINGING);
  assign bus.Snoozing = (state == SNOOZE);

endmodule
